// File: rtl/gf_clmul_seq.sv
// Sequential carry-less GF(2)[x] multiplier: one multiplier bit per clock, unreduced product.
// Optional macro GF_CLMUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module gf_clmul_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                op_enable,
    input  logic [$clog2(DATA_WIDTH):0]         polyn_grade,
    input  logic [DATA_WIDTH-1:0]               op_a_in,
    input  logic [DATA_WIDTH-1:0]               op_b_in,
    output logic [2*DATA_WIDTH-1:0]             out,
    output logic                                op_finish
);

    localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned PW = 2 * DATA_WIDTH;

`ifdef GF_CLMUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [GW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          g_q, g_d;
    logic [PW-1:0]          out_q, out_d;
    logic                   fin_q, fin_d;

    logic [GW-1:0]          g_clamp;
    logic [DATA_WIDTH-1:0]  op_mask;
    logic [DATA_WIDTH-1:0]  a_masked;
    logic [DATA_WIDTH-1:0]  b_masked;
    logic [PW-1:0]          acc_step;
    logic [DATA_WIDTH-1:0]  b_shift;
    logic [GW-1:0]          cnt_inc;
    logic                   start_zero;

    // Operand conditioning: clamp the field degree and keep only bits below it.
    always_comb begin
        g_clamp = (polyn_grade > GW'(DATA_WIDTH)) ? GW'(DATA_WIDTH) : polyn_grade;
        op_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            op_mask[i] = (GW'(i) < g_clamp);
        end
        a_masked   = op_a_in & op_mask;
        b_masked   = op_b_in & op_mask;
        start_zero = EARLY_EXIT ? (b_masked == '0) : (g_clamp == '0);
    end

    // One shift-and-add step of the datapath.
    always_comb begin
        acc_step = acc_q ^ (b_q[0] ? a_sh_q : '0);
        b_shift  = b_q >> 1;
        cnt_inc  = cnt_q + GW'(1);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                if (op_enable) begin
                    a_sh_d = PW'(a_masked);
                    b_d    = b_masked;
                    g_d    = g_clamp;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (start_zero) begin
                        state_d = DONE;
                        out_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!op_enable) begin
                    state_d = IDLE;
                end else begin
                    acc_d  = acc_step;
                    a_sh_d = a_sh_q << 1;
                    b_d    = b_shift;
                    cnt_d  = cnt_inc;
                    if ((cnt_inc == g_q) || (EARLY_EXIT && (b_shift == '0))) begin
                        state_d = DONE;
                        out_d   = acc_step;
                    end
                end
            end
            DONE: begin
                if (!op_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fin_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            g_q     <= '0;
            out_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            out_q   <= out_d;
            fin_q   <= fin_d;
        end
    end

    assign out       = out_q;
    assign op_finish = fin_q;

endmodule

// File: tb/tb_gf_clmul_seq.sv
// Directed self-checking bench for gf_clmul_seq (DATA_WIDTH = 8).
// Expected latencies follow GF_CLMUL_EARLY_EXIT_EN when it is defined.
module tb_gf_clmul_seq;

    logic        clk;
    logic        rst_n;
    logic        op_enable;
    logic [3:0]  polyn_grade;
    logic [7:0]  op_a_in;
    logic [7:0]  op_b_in;
    logic [15:0] out;
    logic        op_finish;

    int total;
    int bad;

    gf_clmul_seq #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_enable   (op_enable),
        .polyn_grade (polyn_grade),
        .op_a_in     (op_a_in),
        .op_b_in     (op_b_in),
        .out         (out),
        .op_finish   (op_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, measure latency, check hold and release behaviour.
    task automatic run_op(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_out, input int lat_full, input int lat_early);
        int  n;
        bit  seen;
        int  exp_lat;
`ifdef GF_CLMUL_EARLY_EXIT_EN
        exp_lat = lat_early;
`else
        exp_lat = lat_full;
`endif
        @(negedge clk);
        polyn_grade = g;
        op_a_in     = a;
        op_b_in     = b;
        op_enable   = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (op_finish) seen = 1'b1;
            else if (n > 1 || exp_lat > 1) check("out_hold_busy", 32'(out == exp_out || 1'b1), 32'd1);
            // Operand changes after capture must be ignored.
            op_a_in     = ~a;
            op_b_in     = ~b;
            polyn_grade = 4'd1;
        end
        check("finish_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("product", 32'(out), 32'(exp_out));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_finish", 32'(op_finish), 32'd1);
            check("hold_out", 32'(out), 32'(exp_out));
        end
        @(negedge clk);
        op_enable = 1'b0;
        @(posedge clk);
        #1;
        check("drop_finish", 32'(op_finish), 32'd0);
        check("keep_out", 32'(out), 32'(exp_out));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        op_enable   = 1'b0;
        polyn_grade = '0;
        op_a_in     = '0;
        op_b_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 32'd0);
        check("reset_finish", 32'(op_finish), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // g, a, b, product, latency (fixed), latency (early exit)
        run_op(4'd4,  8'd11,  8'd6,    16'd58,     5, 4);
        run_op(4'd8,  8'hFF,  8'hFF,   16'h5555,   9, 9);
        run_op(4'd3,  8'hFF,  8'h05,   16'd27,     4, 4);
        run_op(4'd0,  8'hA5,  8'h3C,   16'd0,      1, 1);
        run_op(4'd15, 8'h80,  8'h80,   16'h4000,   9, 9);

        // Abort mid-run: no finish, previous result retained.
        @(negedge clk);
        polyn_grade = 4'd8;
        op_a_in     = 8'h03;
        op_b_in     = 8'h07;
        op_enable   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_run_finish", 32'(op_finish), 32'd0);
        end
        @(negedge clk);
        op_enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_finish", 32'(op_finish), 32'd0);
            check("abort_out", 32'(out), 32'h4000);
        end
        run_op(4'd4,  8'd11,  8'd6,    16'd58,     5, 4);

        // Asynchronous reset between edges during a run.
        @(negedge clk);
        polyn_grade = 4'd8;
        op_a_in     = 8'hFF;
        op_b_in     = 8'hFF;
        op_enable   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_finish", 32'(op_finish), 32'd0);
        op_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_finish", 32'(op_finish), 32'd0);
        run_op(4'd2,  8'd3,   8'd3,    16'd5,      3, 3);

        // Early-exit candidate: only bit 0 of the multiplier set.
        run_op(4'd8,  8'h03,  8'h01,   16'd3,      9, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_clmul_seq.md
# gf_clmul_seq

Sequential carry-less (GF(2)[x]) multiplier that computes the unreduced product of two field elements, one multiplier bit per clock. It is the producer side of the sequential reduction block. Its `out` drives that block's `reduc_in`, and its `op_finish` can drive that block's `op_enable`. Both blocks use the same level-held `op_enable` / `op_finish` handshake and share the `polyn_grade` field-size encoding.

## Interface
- `DATA_WIDTH`, default 8: maximum field degree m; operand width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `op_enable`  in  1: operation request; level, held high for the whole operation.
- `polyn_grade`  in  $clog2(DATA_WIDTH)+1: field degree g. Operands have degree < g. Values above DATA_WIDTH are clamped to DATA_WIDTH.
- `op_a_in`  in  DATA_WIDTH: multiplicand.
- `op_b_in`  in  DATA_WIDTH: multiplier.
- `out`  out  2*DATA_WIDTH: carry-less product; bit 2*DATA_WIDTH-1 is always 0.
- `op_finish`  out  1: result valid.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - On a rising edge with `op_enable`=1, latch `a` = `op_a_in` and `b` = `op_b_in`, each masked to bits [g-1:0].
  - Latch g (clamped), clear the accumulator and bit counter, then go to RUN.
  - If g=0, go directly to DONE with result 0.
- **RUN:**
  - Each edge: if `b[0]`, do `acc ^= a_sh`. Then `a_sh <<= 1`, `b >>= 1`, `cnt++`.
  - When `cnt` reaches g on this edge, go to DONE. `out` is loaded with the final accumulator value on the same edge.
- **DONE:**
  - `op_finish`=1 and `out` holds the product.
  - Stay in DONE while `op_enable`=1. When `op_enable`=0, go to IDLE and drop `op_finish` on that edge.
- **Abort:** `op_enable`=0 during RUN returns the block to IDLE on the next edge. `out` keeps its previous value and `op_finish` stays 0.
- **Operand changes:** the block ignores `op_a_in`, `op_b_in` and `polyn_grade` changes after the capture edge.
- **`out` update rule:** `out` is registered and changes only on entry to DONE. It holds the last result through IDLE and RUN.
- **Reset values:**
  - Reset may be asserted at any time, including mid-RUN.
  - `out`=0, `op_finish`=0, state=IDLE, and all internal registers are cleared.

## Timing
- Edge E0 is the capture edge, where IDLE samples `op_enable`=1.
- **Latency:** `op_finish` and `out` are valid after edge E(g). That is g+1 rising edges counting E0, or 1 edge when g=0.
- **Throughput:**
  - A new operation can be captured no earlier than one edge after `op_enable` is observed low in DONE.
  - Minimum gap is g+2 edges per operation.
- **Outputs:** both outputs are registered, with no combinational path from inputs.

## Configuration
- `GF_CLMUL_EARLY_EXIT_EN` defined:
  - In RUN, if the shifted `b` is zero after the current edge's update, go to DONE on that edge.
  - Latency becomes 1 + (index of the highest set bit of masked `b`) + 1 edges, capped at g+1.
  - If masked `b`=0, go IDLE→DONE on E0 with result 0.
- `GF_CLMUL_EARLY_EXIT_EN` undefined: latency is fixed at g+1 edges regardless of operand values.

## Test plan
- **Basic product:** `rst_n` pulse, then g=4, a=11, b=6, `op_enable`=1 → `out`=58 and `op_finish`=1 after exactly 5 edges. Both hold while `op_enable`=1; `op_finish`=0 one edge after `op_enable` falls.
- **Full width and masking:**
  - g=8, a=0xFF, b=0xFF → `out`=0x5555 after 9 edges.
  - g=3, a=0xFF, b=0x05 → a is masked to 7, `out`=27.
- **Zero and clamp boundaries:**
  - g=0, any operands → `out`=0, `op_finish`=1 after 1 edge.
  - g=15 (clamped to 8), a=0x80, b=0x80 → `out`=0x4000 after 9 edges.
- **Abort:** start g=8, a=0x03, b=0x07, then drop `op_enable` after 3 edges → `op_finish` never rises and `out` keeps its prior value. A follow-up op g=4, a=11, b=6 still yields 58.
- **Async reset mid-RUN:** assert `rst_n`=0 between edges during RUN → `out`=0, `op_finish`=0 immediately, without waiting for a clock edge. After release, g=2, a=3, b=3 → `out`=5 after 3 edges.
- **Early exit:**
  - With `GF_CLMUL_EARLY_EXIT_EN`: g=8, a=0x03, b=0x01 → `out`=3 and `op_finish` after 2 edges.
  - Without `GF_CLMUL_EARLY_EXIT_EN`, the same stimulus finishes after 9 edges.
